// File: rtl/sram_controller_pkg.sv
// Shared state encoding, widths and address-map helper for the 32-to-16-bit SRAM bridge.
package sram_controller_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int unsigned DEFAULT_ADDR_BASE = 1024;
    localparam int unsigned SRAM_AW           = 18;
    localparam int unsigned SRAM_DW           = 16;

    // 32-bit word index relative to the SRAM base, wrapped to the 17 bits the pins can carry.
    function automatic logic [SRAM_AW-2:0] word_addr(input logic [31:0] address,
                                                     input logic [31:0] base);
        logic [31:0] offset;
        offset = address - base;
        return offset[SRAM_AW:2];
    endfunction

endpackage

// File: rtl/sram_controller_if.sv
// Memory-stage request/response bus between the pipeline and the SRAM controller.
interface sram_controller_if;

    logic        wr_en;
    logic        rd_en;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        ready;

    modport master (
        output wr_en, rd_en, address, write_data,
        input  read_data, ready
    );

    modport slave (
        input  wr_en, rd_en, address, write_data,
        output read_data, ready
    );

endinterface

// File: rtl/sram_controller.sv
// Splits each 32-bit load/store into two 16-bit SRAM accesses (low half, then high half)
// and holds the pipeline via ready until the pair completes.
module sram_controller
    import sram_controller_pkg::*;
#(
    parameter int unsigned ACCESS_CYCLES = 3,
    parameter int unsigned ADDR_BASE     = DEFAULT_ADDR_BASE
) (
    input  logic               clk,
    input  logic               rst,
    sram_controller_if.slave   bus,
    inout  wire  [SRAM_DW-1:0] SRAM_DQ,
    output logic [SRAM_AW-1:0] SRAM_ADDR,
    output logic               SRAM_UB_N,
    output logic               SRAM_LB_N,
    output logic               SRAM_WE_N,
    output logic               SRAM_CE_N,
    output logic               SRAM_OE_N
);

    localparam int unsigned     CW   = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;
    localparam logic [CW-1:0]   LAST = CW'(ACCESS_CYCLES - 1);

    state_t             state, state_d;
    logic [CW-1:0]      count, count_d;
    logic [SRAM_AW-2:0] word_q;
    logic [31:0]        wdata_q;
    logic               op_write;
    logic [31:0]        read_data_q;
    logic [SRAM_AW-1:0] sram_addr_d;
    logic               latch;
    logic               cap_lo;
    logic               cap_hi;
    logic               drive;

    always_comb begin
        state_d     = state;
        count_d     = count;
        sram_addr_d = SRAM_ADDR;
        latch       = 1'b0;
        cap_lo      = 1'b0;
        cap_hi      = 1'b0;
        case (state)
            IDLE: begin
                if (bus.wr_en || bus.rd_en) begin
                    latch       = 1'b1;
                    count_d     = '0;
                    state_d     = LOW;
                    sram_addr_d = {word_addr(bus.address, ADDR_BASE), 1'b0};
                end
            end
            LOW: begin
                if (count == LAST) begin
                    cap_lo      = ~op_write;
                    count_d     = '0;
                    state_d     = HIGH;
                    sram_addr_d = {word_q, 1'b1};
                end else begin
                    count_d = count + CW'(1);
                end
            end
            HIGH: begin
                if (count == LAST) begin
                    cap_hi  = ~op_write;
                    count_d = '0;
                    state_d = DONE;
                end else begin
                    count_d = count + CW'(1);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            count       <= '0;
            word_q      <= '0;
            wdata_q     <= '0;
            op_write    <= 1'b0;
            read_data_q <= '0;
            SRAM_ADDR   <= '0;
        end else begin
            state     <= state_d;
            count     <= count_d;
            SRAM_ADDR <= sram_addr_d;
            if (latch) begin
                word_q   <= word_addr(bus.address, ADDR_BASE);
                wdata_q  <= bus.write_data;
                op_write <= bus.wr_en;
            end
            if (cap_lo) read_data_q[15:0]  <= SRAM_DQ;
            if (cap_hi) read_data_q[31:16] <= SRAM_DQ;
        end
    end

    // WE_N derives from state alone, so it stays low without a gap across the LOW->HIGH edge.
    assign drive     = op_write && ((state == LOW) || (state == HIGH));
    assign SRAM_WE_N = ~drive;
    assign SRAM_DQ   = drive ? ((state == HIGH) ? wdata_q[31:16] : wdata_q[15:0]) : 'z;

    assign SRAM_UB_N = 1'b0;
    assign SRAM_LB_N = 1'b0;
    assign SRAM_CE_N = 1'b0;
    assign SRAM_OE_N = 1'b0;

    assign bus.read_data = read_data_q;
    assign bus.ready     = ~(bus.wr_en | bus.rd_en) | (state == DONE);

endmodule

// File: tb/tb_sram_controller.sv
// Scoreboard bench for sram_controller with a behavioural 16-bit SRAM that commits only full-length writes.
module tb_sram_controller;

    localparam int unsigned AC      = 3;
    localparam int          TIMEOUT = 40;

    logic        clk = 1'b0;
    logic        rst;
    wire  [15:0] sram_dq;
    logic [17:0] sram_addr;
    logic        sram_ub_n, sram_lb_n, sram_we_n, sram_ce_n, sram_oe_n;

    sram_controller_if bus();

    sram_controller #(
        .ACCESS_CYCLES(AC),
        .ADDR_BASE    (1024)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus.slave),
        .SRAM_DQ  (sram_dq),
        .SRAM_ADDR(sram_addr),
        .SRAM_UB_N(sram_ub_n),
        .SRAM_LB_N(sram_lb_n),
        .SRAM_WE_N(sram_we_n),
        .SRAM_CE_N(sram_ce_n),
        .SRAM_OE_N(sram_oe_n)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] sb_q[$];

    // SRAM model: a half-word is stored only if WE_N stayed low on that address for a full access.
    logic [15:0] mem [0:63];
    bit          mem_init = 1'b0;
    bit          model_en = 1'b0;
    bit          wr_open  = 1'b0;
    logic [17:0] wr_addr;
    logic [15:0] wr_dat;
    int          wr_len;

    assign sram_dq = (model_en && sram_we_n === 1'b1) ? mem[sram_addr[5:0]] : 16'hzzzz;

    always @(negedge clk) begin
        if (!mem_init) begin
            for (int i = 0; i < 64; i++) mem[i] = 16'h0000;
            mem_init = 1'b1;
        end
        if (sram_we_n === 1'b0) begin
            if (wr_open && sram_addr == wr_addr) begin
                wr_len++;
            end else begin
                if (wr_open && wr_len >= AC) mem[wr_addr[5:0]] = wr_dat;
                wr_open = 1'b1;
                wr_addr = sram_addr;
                wr_len  = 1;
            end
            wr_dat = sram_dq;
        end else if (wr_open) begin
            if (wr_len >= AC) mem[wr_addr[5:0]] = wr_dat;
            wr_open = 1'b0;
        end
    end

    bit          mon_en = 1'b0;
    int          we_low_cycles;
    int          we_runs;
    logic        we_prev = 1'b1;
    logic [17:0] we_addrs[$];

    always @(negedge clk) begin
        if (mon_en && sram_we_n === 1'b0) begin
            we_low_cycles++;
            if (we_prev) we_runs++;
            if (we_addrs.size() == 0 || we_addrs[$] != sram_addr) we_addrs.push_back(sram_addr);
        end
        we_prev = sram_we_n;
    end

    function automatic bit dq_released();
        return (sram_dq === 16'hzzzz) || (sram_dq === 16'h0000);
    endfunction

    // Called right after a posedge; returns the cycle index at which ready was first seen high.
    task automatic run_req(input logic wr, input logic rd, input logic [31:0] a,
                           input logic [31:0] wd, input bit keep, output int lat);
        logic [31:0] exp;
        bus.wr_en      = wr;
        bus.rd_en      = rd;
        bus.address    = a;
        bus.write_data = wd;
        lat = 0;
        @(negedge clk);
        while (bus.ready !== 1'b1 && lat < TIMEOUT) begin
            @(negedge clk);
            lat++;
        end
        if (lat >= TIMEOUT) begin
            checks++; errors++;
            $display("FAIL ready_timeout: ready=%b after %0d cycles, required 1", bus.ready, lat);
        end else if (rd && !wr) begin
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL scoreboard_empty: read completed with no expected value queued");
            end else begin
                exp = sb_q.pop_front();
                if (bus.read_data !== exp) begin
                    errors++;
                    $display("FAIL read_data: got %h, required %h", bus.read_data, exp);
                end
            end
        end
        @(posedge clk); #1;
        if (!keep) begin
            bus.wr_en = 1'b0;
            bus.rd_en = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst            = 1'b1;
        bus.wr_en      = 1'b0;
        bus.rd_en      = 1'b0;
        bus.address    = '0;
        bus.write_data = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checks++; if (bus.ready !== 1'b1)       begin errors++; $display("FAIL reset_ready: got %b, required 1", bus.ready); end
        checks++; if (sram_we_n !== 1'b1)       begin errors++; $display("FAIL reset_we_n: got %b, required 1", sram_we_n); end
        checks++; if (sram_addr !== 18'd0)      begin errors++; $display("FAIL reset_addr: got %h, required 0", sram_addr); end
        checks++; if (bus.read_data !== 32'd0)  begin errors++; $display("FAIL reset_read_data: got %h, required 0", bus.read_data); end
        checks++; if (!dq_released())           begin errors++; $display("FAIL reset_dq: got %h, required Z", sram_dq); end
        @(posedge clk); #1;
    endtask

    task automatic test_write_read();
        int lat;
        model_en = 1'b1;
        run_req(1'b1, 1'b0, 32'd1024, 32'hDEADBEEF, 1'b0, lat);
        checks++; if (lat != 7)                 begin errors++; $display("FAIL write_latency: got %0d, required 7", lat); end
        checks++; if (mem[0] !== 16'hBEEF)      begin errors++; $display("FAIL write_low_half: got %h, required BEEF", mem[0]); end
        checks++; if (mem[1] !== 16'hDEAD)      begin errors++; $display("FAIL write_high_half: got %h, required DEAD", mem[1]); end
        sb_q.push_back(32'hDEADBEEF);
        run_req(1'b0, 1'b1, 32'd1024, 32'h5A5AA5A5, 1'b0, lat);
        checks++; if (lat != 7)                 begin errors++; $display("FAIL read_latency: got %0d, required 7", lat); end
    endtask

    task automatic test_addr_map();
        int lat;
        we_low_cycles = 0;
        we_runs       = 0;
        we_addrs.delete();
        mon_en = 1'b1;
        run_req(1'b1, 1'b0, 32'd1032, 32'h00000011, 1'b0, lat);
        mon_en = 1'b0;
        checks++; if (we_low_cycles != 6 || we_runs != 1) begin
            errors++; $display("FAIL we_n_pulse: got %0d low cycles in %0d runs, required 6 in 1", we_low_cycles, we_runs);
        end
        checks++; if (we_addrs.size() != 2 || we_addrs[0] !== 18'd4 || we_addrs[1] !== 18'd5) begin
            errors++; $display("FAIL addr_sequence: got %0d addresses first=%0d, required 4 then 5",
                               we_addrs.size(), (we_addrs.size() > 0) ? we_addrs[0] : 18'h3FFFF);
        end
        checks++; if (lat != 7)                 begin errors++; $display("FAIL addr_map_latency: got %0d, required 7", lat); end
        checks++; if (mem[4] !== 16'h0011)      begin errors++; $display("FAIL addr_map_low: got %h, required 0011", mem[4]); end
        checks++; if (mem[5] !== 16'h0000)      begin errors++; $display("FAIL addr_map_high: got %h, required 0000", mem[5]); end
    endtask

    task automatic test_idle();
        model_en = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (bus.ready !== 1'b1)       begin errors++; $display("FAIL idle_ready: got %b, required 1", bus.ready); end
        checks++; if (sram_we_n !== 1'b1)       begin errors++; $display("FAIL idle_we_n: got %b, required 1", sram_we_n); end
        checks++; if (!dq_released())           begin errors++; $display("FAIL idle_dq: got %h, required Z", sram_dq); end
        @(posedge clk); #1;
        model_en = 1'b1;
    endtask

    task automatic test_both();
        int lat;
        run_req(1'b1, 1'b1, 32'd1036, 32'hCAFEF00D, 1'b0, lat);
        checks++; if (lat != 7)                      begin errors++; $display("FAIL both_latency: got %0d, required 7", lat); end
        checks++; if (bus.read_data !== 32'hDEADBEEF) begin errors++; $display("FAIL both_read_data_kept: got %h, required DEADBEEF", bus.read_data); end
        checks++; if (mem[6] !== 16'hF00D)           begin errors++; $display("FAIL both_low_half: got %h, required F00D", mem[6]); end
        checks++; if (mem[7] !== 16'hCAFE)           begin errors++; $display("FAIL both_high_half: got %h, required CAFE", mem[7]); end
    endtask

    task automatic test_back_to_back();
        int lat1, lat2, latw;
        run_req(1'b1, 1'b0, 32'd1028, 32'h12345678, 1'b0, latw);
        checks++; if (latw != 7) begin errors++; $display("FAIL b2b_write_latency: got %0d, required 7", latw); end
        sb_q.push_back(32'hDEADBEEF);
        sb_q.push_back(32'h12345678);
        run_req(1'b0, 1'b1, 32'd1024, 32'h5A5AA5A5, 1'b1, lat1);
        run_req(1'b0, 1'b1, 32'd1028, 32'h5A5AA5A5, 1'b0, lat2);
        checks++; if (lat1 != 7)     begin errors++; $display("FAIL b2b_first_latency: got %0d, required 7", lat1); end
        checks++; if (lat2 + 1 != 8) begin errors++; $display("FAIL b2b_gap: got %0d cycles between readies, required 8", lat2 + 1); end
    endtask

    task automatic test_reset_mid();
        int lat;
        bus.wr_en      = 1'b1;
        bus.rd_en      = 1'b0;
        bus.address    = 32'd1024;
        bus.write_data = 32'h33334444;
        repeat (4) @(posedge clk);
        #1;
        rst       = 1'b1;
        bus.wr_en = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checks++; if (sram_we_n !== 1'b1)  begin errors++; $display("FAIL rst_mid_we_n: got %b, required 1", sram_we_n); end
        checks++; if (bus.ready !== 1'b1)  begin errors++; $display("FAIL rst_mid_ready: got %b, required 1", bus.ready); end
        checks++; if (sram_we_n === 1'b0 || sram_dq === 16'h3333)
                                           begin errors++; $display("FAIL rst_mid_dq: got %h, required Z", sram_dq); end
        @(negedge clk);
        checks++; if (mem[1] !== 16'hDEAD) begin errors++; $display("FAIL rst_mid_high_untouched: got %h, required DEAD", mem[1]); end
        checks++; if (mem[0] !== 16'h4444) begin errors++; $display("FAIL rst_mid_low_written: got %h, required 4444", mem[0]); end
        @(posedge clk); #1;
        sb_q.push_back(32'hDEAD4444);
        run_req(1'b0, 1'b1, 32'd1024, 32'h5A5AA5A5, 1'b0, lat);
        checks++; if (lat != 7)            begin errors++; $display("FAIL rst_mid_next_latency: got %0d, required 7", lat); end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_addr_map();
        test_idle();
        test_both();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sram_controller.md
Name: sram_controller

Overview:
- Sits directly downstream of the memory stage and bridges it to the external 16-bit SRAM.
- Converts one 32-bit word read or write into two sequential 16-bit SRAM accesses: low half first, then high half.
- Drives `ready` low while the access is in flight. The datapath uses this signal as mem_ready to freeze every pipeline register.

Parameters:
- ACCESS_CYCLES, 3: cycles each 16-bit half-access is held on the SRAM pins (minimum 1).
- ADDR_BASE, 1024: byte address that maps to SRAM word 0.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset
- wr_en  input  1  write request from the memory stage
- rd_en  input  1  read request from the memory stage
- address  input  32  byte address (ALU result)
- write_data  input  32  store data (Rm value)
- read_data  output  32  load result, registered
- ready  output  1  high when no request is pending or the current request completes this cycle
- SRAM_DQ  inout  16  SRAM data bus
- SRAM_ADDR  output  18  SRAM half-word address
- SRAM_UB_N  output  1  upper byte enable, tied 0
- SRAM_LB_N  output  1  lower byte enable, tied 0
- SRAM_WE_N  output  1  write enable, active low
- SRAM_CE_N  output  1  chip enable, tied 0
- SRAM_OE_N  output  1  output enable, tied 0

Behaviour:
- Single clock `clk`. Reset `rst` is synchronous and active-high.
- Reset values: state IDLE, counter 0, read_data 0, SRAM_WE_N 1, SRAM_DQ high-Z, SRAM_ADDR 0, latched operands 0.
- Address map: word_addr = (address - ADDR_BASE) >> 2, truncated to 17 bits (modulo wrap, no range check).
  - Low half-word is at {word_addr, 1'b0}.
  - High half-word is at {word_addr, 1'b1}.
- States are IDLE, LOW, HIGH, DONE.
- IDLE:
  - If wr_en or rd_en is high, latch address, write_data and op (write wins if both are asserted), clear the counter, and go to LOW.
  - Otherwise stay in IDLE.
- LOW:
  - SRAM_ADDR = low address.
  - For a write: SRAM_WE_N = 0 and SRAM_DQ = write_data[15:0].
  - For a read: SRAM_WE_N = 1 and SRAM_DQ is high-Z.
  - On the cycle where counter = ACCESS_CYCLES-1: a read samples SRAM_DQ into read_data[15:0]; then clear the counter and go to HIGH.
  - Otherwise increment the counter.
- HIGH:
  - Same as LOW, using the high address and write_data[31:16] / read_data[31:16].
  - Exits to DONE.
- DONE:
  - SRAM_WE_N = 1 and SRAM_DQ is high-Z.
  - Go to IDLE unconditionally.
- ready (combinational) = ~(wr_en | rd_en) | (state == DONE).
  - ready is therefore low in the same cycle a new request appears.
- Latency:
  - A request first seen in IDLE at cycle 0 has ready high at cycle 2*ACCESS_CYCLES+1.
  - That is 7 cycles for the default parameter.
  - The pipeline advances on that edge.
- Back-to-back requests:
  - After DONE the controller spends one IDLE cycle before starting the next request.
  - ready stays low through that IDLE cycle if the next request is already present.
- Request dropped mid-transaction: the transaction completes using the latched operands, and ready follows the formula above.
- read_data:
  - Holds its value until the next read overwrites it.
  - Writes never modify it.
  - During a read, the low half updates before the high half. read_data is only guaranteed valid when ready is high.
- SRAM_WE_N never glitches between halves of a write: it stays 0 continuously from LOW entry to HIGH exit.
- SRAM_ADDR changes only on state transitions.
- Reset asserted mid-transaction: the controller returns to IDLE on the next edge and releases SRAM_WE_N to 1 and SRAM_DQ to high-Z in the same cycle. The partial write is not completed.

Decomposition:
- Shared package holds:
  - the state encoding (2-bit, IDLE=0, LOW=1, HIGH=2, DONE=3);
  - the default ADDR_BASE constant;
  - the SRAM address width (18) and data width (16) constants.
- No sub-module. The counter and FSM live in one module, and the tri-state driver is a continuous assignment.

Test Plan:
- Write then read, ACCESS_CYCLES=3:
  - Write 0xDEADBEEF to address 1024: ready is low for cycles 0-6 and high at cycle 7.
  - The SRAM model then holds 0xBEEF at half-word 0 and 0xDEAD at half-word 1.
  - A read of address 1024 returns read_data 0xDEADBEEF with ready high 7 cycles after the request.
- Address map: write 0x00000011 to address 1032, then check that SRAM_ADDR carried 4 and then 5, and that WE_N stayed low for exactly 6 consecutive cycles.
- Idle: with no request, ready is 1, WE_N is 1, and SRAM_DQ is Z.
- Both wr_en and rd_en held: the controller performs a write, and read_data is unchanged.
- Back-to-back reads of 1024 and 1028:
  - The second ready arrives 8 cycles after the first.
  - read_data matches each stored word.
- Reset pulse in HIGH during a write:
  - The next cycle shows state IDLE, WE_N 1 and DQ Z.
  - The high half-word is untouched.
  - A subsequent request behaves normally, with 7-cycle latency.
